axil_gpio_multi: RTL and testbench

- AXI-Lite slave GPIO block with NumChannels independent channels of GPIOWidth bits each.
- Every pin has a software-programmable direction (tri-state) bit, an output data register and a synchronised input path.
- Optional per-bit input-change interrupts.
- Sits behind the AXI-Lite demux. Unlike the earlier fixed-mode GPIO, it decodes its own local address space and drives the pad io_i/io_o/io_t triplets directly.

---
 rtl/axil_gpio_multi.sv | 238 +++++++++++++++++++++++
 tb/tb_axil_gpio_multi.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_gpio_multi.sv
// axil_gpio_multi -- AXI-Lite slave GPIO with NumChannels channels of GPIOWidth pins.
//
// Each pin has a direction bit (TRI, 1 = input/high-Z), an output data bit and a
// synchronised input path. Each channel decodes a 16-byte window at c*0x10:
//   +0x0 DATA      read (sync_in & TRI) | (DATA_OUT & ~TRI), write DATA_OUT
//   +0x4 TRI       read/write
//   +0x8 IRQ_MASK  read/write                (reads 0 without AXIL_GPIO_IRQ_EN)
//   +0xC IRQ_STAT  read, write-1-to-clear    (reads 0 without AXIL_GPIO_IRQ_EN)
// Addresses outside the channel windows answer SLVERR.
//
// Optional feature macro: AXIL_GPIO_IRQ_EN -- per-bit any-edge input-change
// interrupts on input pins, with a registered level interrupt output.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   s_axil_req   AXI-Lite request (aw/w/b/ar/r channel master signals)
//   s_axil_resp  AXI-Lite response, all fields registered
//   io_i         pad inputs, channel c at [c*GPIOWidth +: GPIOWidth]
//   io_o         pad outputs (DATA_OUT)
//   io_t         pad tri-state enables (TRI, 1 = high-Z)
//   irq          level interrupt, OR of enabled pending bits
module axil_gpio_multi #(
    parameter type axil_req_t = struct packed {
        logic aw_valid;
        struct packed { logic [31:0] addr; } aw;
        logic w_valid;
        struct packed { logic [31:0] data; logic [3:0] strb; } w;
        logic b_ready;
        logic ar_valid;
        struct packed { logic [31:0] addr; } ar;
        logic r_ready;
    },
    parameter type axil_resp_t = struct packed {
        logic aw_ready;
        logic w_ready;
        logic b_valid;
        struct packed { logic [1:0] resp; } b;
        logic ar_ready;
        logic r_valid;
        struct packed { logic [31:0] data; logic [1:0] resp; } r;
    },
    parameter int NumChannels = 2,
    parameter int GPIOWidth   = 32,
    parameter int SyncStages  = 2,
    parameter logic [GPIOWidth-1:0] DefaultOut = '0,
    parameter logic [GPIOWidth-1:0] DefaultTri = '1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  axil_req_t                        s_axil_req,
    output axil_resp_t                       s_axil_resp,
    input  logic [NumChannels*GPIOWidth-1:0] io_i,
    output logic [NumChannels*GPIOWidth-1:0] io_o,
    output logic [NumChannels*GPIOWidth-1:0] io_t,
    output logic                             irq
);

    localparam logic [31:0] AddrLimit = 32'(NumChannels * 16);

    typedef enum logic [2:0] {IDLE, WR_ACK, WR_RESP, RD_ACK, RD_RESP} state_t;

    state_t     state_q, state_d;
    axil_resp_t resp_q;

    logic [GPIOWidth-1:0] data_out [NumChannels];
    logic [GPIOWidth-1:0] tri_q    [NumChannels];
    logic [GPIOWidth-1:0] sync_ch  [NumChannels];

    logic [NumChannels*GPIOWidth-1:0] sync_p [SyncStages];
    logic [NumChannels*GPIOWidth-1:0] sync_in;

    logic [31:0]            wr_addr, rd_addr, rd_data;
    logic                   wr_ok, rd_ok, wr_en;
    logic [NumChannels-1:0] wr_sel;
    logic [GPIOWidth-1:0]   wr_bits;

    // Write wins over a simultaneous read; a lone aw_valid waits for w_valid.
    function automatic state_t start_next(input logic aw_v, input logic w_v, input logic ar_v);
        if (aw_v && w_v) return WR_ACK;
        if (ar_v && !aw_v) return RD_ACK;
        return IDLE;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A new transaction may be accepted in the same cycle the response handshakes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_next(s_axil_req.aw_valid, s_axil_req.w_valid, s_axil_req.ar_valid);
            WR_ACK:  state_d = WR_RESP;
            WR_RESP: if (s_axil_req.b_ready)
                         state_d = start_next(s_axil_req.aw_valid, s_axil_req.w_valid, s_axil_req.ar_valid);
            RD_ACK:  state_d = RD_RESP;
            RD_RESP: if (s_axil_req.r_ready)
                         state_d = start_next(s_axil_req.aw_valid, s_axil_req.w_valid, s_axil_req.ar_valid);
            default: state_d = IDLE;
        endcase
    end

    // aw/w payloads stay valid until the ready pulse, so they are used directly in WR_ACK.
    assign wr_addr = s_axil_req.aw.addr;
    assign rd_addr = s_axil_req.ar.addr;
    assign wr_ok   = wr_addr < AddrLimit;
    assign rd_ok   = rd_addr < AddrLimit;
    assign wr_en   = (state_q == WR_ACK) && wr_ok;

    always_comb begin
        wr_sel  = '0;
        wr_bits = '0;
        for (int c = 0; c < NumChannels; c++)
            wr_sel[c] = wr_en && ((wr_addr >> 4) == 32'(c));
        for (int i = 0; i < GPIOWidth; i++)
            wr_bits[i] = s_axil_req.w.strb[i / 8];
    end

    // ---- input synchroniser: pad -> sync_p[0] -> ... -> sync_in ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SyncStages; s++) sync_p[s] <= '0;
        end else begin
            sync_p[0] <= io_i;
            for (int s = 1; s < SyncStages; s++) sync_p[s] <= sync_p[s-1];
        end
    end
    assign sync_in = sync_p[SyncStages-1];

    for (genvar c = 0; c < NumChannels; c++) begin : g_pads
        assign sync_ch[c]                          = sync_in[c*GPIOWidth +: GPIOWidth];
        assign io_o[c*GPIOWidth +: GPIOWidth]      = data_out[c];
        assign io_t[c*GPIOWidth +: GPIOWidth]      = tri_q[c];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NumChannels; c++) begin
                data_out[c] <= DefaultOut;
                tri_q[c]    <= DefaultTri;
            end
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                for (int i = 0; i < GPIOWidth; i++) begin
                    if (wr_sel[c] && wr_bits[i]) begin
                        if (wr_addr[3:2] == 2'd0) data_out[c][i] <= s_axil_req.w.data[i];
                        if (wr_addr[3:2] == 2'd1) tri_q[c][i]    <= s_axil_req.w.data[i];
                    end
                end
            end
        end
    end

`ifdef AXIL_GPIO_IRQ_EN
    logic [NumChannels*GPIOWidth-1:0] sync_prev;
    logic [GPIOWidth-1:0] irq_mask [NumChannels];
    logic [GPIOWidth-1:0] irq_stat [NumChannels];
    logic [GPIOWidth-1:0] edge_ch  [NumChannels];
    logic                 pending;
    logic                 irq_q;

    always_comb begin
        pending = 1'b0;
        for (int c = 0; c < NumChannels; c++) begin
            edge_ch[c] = (sync_in[c*GPIOWidth +: GPIOWidth] ^ sync_prev[c*GPIOWidth +: GPIOWidth]) & tri_q[c];
            pending    = pending | (|(irq_stat[c] & irq_mask[c]));
        end
    end

    // A fresh edge beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_prev <= '0;
            irq_q     <= 1'b0;
            for (int c = 0; c < NumChannels; c++) begin
                irq_mask[c] <= '0;
                irq_stat[c] <= '0;
            end
        end else begin
            sync_prev <= sync_in;
            irq_q     <= pending;
            for (int c = 0; c < NumChannels; c++) begin
                for (int i = 0; i < GPIOWidth; i++) begin
                    if (wr_sel[c] && wr_bits[i] && wr_addr[3:2] == 2'd2)
                        irq_mask[c][i] <= s_axil_req.w.data[i];
                    if (edge_ch[c][i])
                        irq_stat[c][i] <= 1'b1;
                    else if (wr_sel[c] && wr_bits[i] && wr_addr[3:2] == 2'd3 && s_axil_req.w.data[i])
                        irq_stat[c][i] <= 1'b0;
                end
            end
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (rd_ok && ((rd_addr >> 4) == 32'(c))) begin
                case (rd_addr[3:2])
                    2'd0: rd_data[GPIOWidth-1:0] = (sync_ch[c] & tri_q[c]) | (data_out[c] & ~tri_q[c]);
                    2'd1: rd_data[GPIOWidth-1:0] = tri_q[c];
`ifdef AXIL_GPIO_IRQ_EN
                    2'd2: rd_data[GPIOWidth-1:0] = irq_mask[c];
                    2'd3: rd_data[GPIOWidth-1:0] = irq_stat[c];
`endif
                    default: rd_data = '0;
                endcase
            end
        end
    end

    // ---- response register: ready/valid follow the next state ----
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_q <= '0;
        end else begin
            resp_q.aw_ready <= (state_d == WR_ACK);
            resp_q.w_ready  <= (state_d == WR_ACK);
            resp_q.b_valid  <= (state_d == WR_RESP);
            resp_q.ar_ready <= (state_d == RD_ACK);
            resp_q.r_valid  <= (state_d == RD_RESP);
            if (state_q == WR_ACK)
                resp_q.b.resp <= wr_ok ? 2'd0 : 2'd2;
            if (state_q == RD_ACK) begin
                resp_q.r.data <= rd_data;
                resp_q.r.resp <= rd_ok ? 2'd0 : 2'd2;
            end
        end
    end
    assign s_axil_resp = resp_q;

endmodule

// File: tb/tb_axil_gpio_multi.sv
// Scoreboard bench for axil_gpio_multi (NumChannels=2, GPIOWidth=32, SyncStages=2).
module tb_axil_gpio_multi;

    typedef struct packed { logic [31:0] addr; } ax_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;
    typedef struct packed { logic [1:0] resp; } b_t;
    typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_t;
    typedef struct packed {
        logic aw_valid; ax_t aw; logic w_valid; w_t w; logic b_ready;
        logic ar_valid; ax_t ar; logic r_ready;
    } req_t;
    typedef struct packed {
        logic aw_ready; logic w_ready; logic b_valid; b_t b;
        logic ar_ready; logic r_valid; r_t r;
    } resp_t;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset;
    req_t        req;
    resp_t       resp;
    logic [63:0] io_i, io_o, io_t;
    logic        irq;

    int vectors    = 0;
    int miscompares = 0;

    logic [1:0]  b_q[$];
    logic [33:0] r_q[$];
    logic [31:0] m_out[2], m_tri[2], m_mask[2], m_stat[2];

    always #5 clk = ~clk;

    axil_gpio_multi #(
        .axil_req_t (req_t),
        .axil_resp_t(resp_t),
        .NumChannels(2),
        .GPIOWidth  (32),
        .SyncStages (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_axil_req (req),
        .s_axil_resp(resp),
        .io_i       (io_i),
        .io_o       (io_o),
        .io_t       (io_t),
        .irq        (irq)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_out[c] = '0; m_tri[c] = '1; m_mask[c] = '0; m_stat[c] = '0;
        end
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm;
        logic        ch;
        if (a >= 32'h20) return;
        ch = a[4];
        bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        case (a[3:2])
            2'd0: m_out[ch] = (m_out[ch] & ~bm) | (d & bm);
            2'd1: m_tri[ch] = (m_tri[ch] & ~bm) | (d & bm);
`ifdef AXIL_GPIO_IRQ_EN
            2'd2: m_mask[ch] = (m_mask[ch] & ~bm) | (d & bm);
            2'd3: m_stat[ch] = m_stat[ch] & ~(d & bm);
`endif
            default: ;
        endcase
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] a);
        logic        ch;
        logic [31:0] pin;
        if (a >= 32'h20) return {2'd2, 32'h0};
        ch  = a[4];
        pin = ch ? io_i[63:32] : io_i[31:0];
        case (a[3:2])
            2'd0:    return {2'd0, (pin & m_tri[ch]) | (m_out[ch] & ~m_tri[ch])};
            2'd1:    return {2'd0, m_tri[ch]};
`ifdef AXIL_GPIO_IRQ_EN
            2'd2:    return {2'd0, m_mask[ch]};
            2'd3:    return {2'd0, m_stat[ch]};
`endif
            default: return {2'd0, 32'h0};
        endcase
    endfunction

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
        int n;
        b_q.push_back((a < 32'h20) ? 2'd0 : 2'd2);
        model_write(a, d, s);
        @(negedge clk);
        req.aw_valid = 1'b1; req.aw.addr = a;
        req.w_valid  = 1'b1; req.w.data = d; req.w.strb = s;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp.aw_ready && n < 20);
        check_val($sformatf("aw_ready_lat@%0h", a), 64'(n), 64'd1);
        check_val("w_ready", 64'(resp.w_ready), 64'd1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        @(negedge clk);
        check_val("aw_ready_pulse", 64'(resp.aw_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            check_val("b_valid_hold", 64'(resp.b_valid), 64'd1);
            @(negedge clk);
        end
        check_val("b_valid", 64'(resp.b_valid), 64'd1);
        req.b_ready = 1'b1;
        check_val($sformatf("bresp@%0h", a), 64'(resp.b.resp), 64'(b_q.pop_front()));
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        @(negedge clk);
        check_val("b_valid_drop", 64'(resp.b_valid), 64'd0);
    endtask

    task automatic axi_read(input logic [31:0] a);
        int n;
        r_q.push_back(model_read(a));
        @(negedge clk);
        req.ar_valid = 1'b1; req.ar.addr = a;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp.ar_ready && n < 20);
        check_val($sformatf("ar_ready_lat@%0h", a), 64'(n), 64'd1);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        @(negedge clk);
        check_val("ar_ready_pulse", 64'(resp.ar_ready), 64'd0);
        check_val("r_valid_lat2", 64'(resp.r_valid), 64'd1);
        req.r_ready = 1'b1;
        check_val($sformatf("rdata@%0h", a), 64'({resp.r.resp, resp.r.data}), 64'(r_q.pop_front()));
        @(posedge clk); #1;
        req.r_ready = 1'b0;
        @(negedge clk);
        check_val("r_valid_drop", 64'(resp.r_valid), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic ar_early;
        reset = 1'b1; req = '0; io_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst_resp", 64'({resp.aw_ready, resp.w_ready, resp.b_valid, resp.ar_ready, resp.r_valid}), 64'd0);
        check_val("rst_io_t", io_t, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("rst_io_o", io_o, 64'h0);
        check_val("rst_irq", 64'(irq), 64'd0);

        // Reset values through the bus.
        axi_read(32'h4);
        axi_read(32'h0);
        axi_read(32'h14);

        // Direction and output data on channel 0, then mixed-direction readback.
        axi_write(32'h4, 32'h0000_FFFF, 4'hF, 0);
        axi_write(32'h0, 32'hA5A5_A5A5, 4'hF, 0);
        check_val("io_t_ch0", 64'(io_t[31:0]), 64'h0000_FFFF);
        check_val("io_o_ch0", 64'(io_o[31:0]), 64'hA5A5_A5A5);
        io_i[31:0] = 32'h1234_0000;
        repeat (SYNC + 1) @(negedge clk);
        axi_read(32'h0);

        // Partial strobe write to channel 1.
        axi_write(32'h10, 32'hDEAD_BEEF, 4'h3, 0);
        check_val("io_o_ch1", 64'(io_o[63:32]), 64'h0000_BEEF);
        check_val("io_o_ch0_keep", 64'(io_o[31:0]), 64'hA5A5_A5A5);
        axi_read(32'h10);

        // Out-of-range accesses.
        axi_read(32'h20);
        axi_write(32'h20, 32'h0, 4'hF, 0);
        check_val("oor_io_o", io_o, {32'h0000_BEEF, 32'hA5A5_A5A5});
        check_val("oor_io_t", io_t, {32'hFFFF_FFFF, 32'h0000_FFFF});

        // addr[1:0] ignored; TRI 1->0 exposes DATA_OUT directly.
        axi_write(32'h17, 32'h0F0F_0F0F, 4'hF, 0);
        check_val("io_t_ch1", 64'(io_t[63:32]), 64'h0F0F_0F0F);
        check_val("io_o_ch1_keep", 64'(io_o[63:32]), 64'h0000_BEEF);
        io_i[63:32] = 32'hFFFF_FFFF;
        repeat (SYNC + 1) @(negedge clk);
        axi_read(32'h10);

        // Simultaneous write and read: write first, read accepted at b handshake.
        b_q.push_back(2'd0);
        model_write(32'h0, 32'h5A5A_0000, 4'hF);
        r_q.push_back(model_read(32'h4));
        @(negedge clk);
        req.aw_valid = 1'b1; req.aw.addr = 32'h0;
        req.w_valid  = 1'b1; req.w.data = 32'h5A5A_0000; req.w.strb = 4'hF;
        req.ar_valid = 1'b1; req.ar.addr = 32'h4;
        ar_early = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (resp.ar_ready) ar_early = 1'b1;
        end while (!resp.aw_ready && n < 20);
        check_val("both_aw_lat", 64'(n), 64'd1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        @(negedge clk);
        if (resp.ar_ready) ar_early = 1'b1;
        check_val("both_b_valid", 64'(resp.b_valid), 64'd1);
        check_val("both_ar_blocked", 64'(ar_early), 64'd0);
        req.b_ready = 1'b1;
        check_val("both_bresp", 64'(resp.b.resp), 64'(b_q.pop_front()));
        @(posedge clk); #1;
        req.b_ready = 1'b0;
        @(negedge clk);
        check_val("both_ar_after_b", 64'(resp.ar_ready), 64'd1);
        check_val("both_b_drop", 64'(resp.b_valid), 64'd0);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        @(negedge clk);
        check_val("both_r_valid", 64'(resp.r_valid), 64'd1);
        req.r_ready = 1'b1;
        check_val("both_rdata", 64'({resp.r.resp, resp.r.data}), 64'(r_q.pop_front()));
        @(posedge clk); #1;
        req.r_ready = 1'b0;
        check_val("both_io_o", 64'(io_o[31:0]), 64'h5A5A_0000);

`ifdef AXIL_GPIO_IRQ_EN
        // Edge on an input pin raises irq SYNC+2 cycles later.
        axi_write(32'h8, 32'h1, 4'hF, 0);
        @(negedge clk);
        io_i[0] = ~io_i[0];
        for (int i = 1; i <= SYNC + 2; i++) begin
            @(negedge clk);
            check_val($sformatf("irq_t%0d", i), 64'(irq), 64'(i == SYNC + 2));
        end
        m_stat[0] = 32'h1;
        axi_read(32'hC);
        axi_write(32'hC, 32'h1, 4'hF, 0);
        check_val("irq_cleared", 64'(irq), 64'd0);
        axi_read(32'hC);
        // Second edge, response held off for 5 cycles.
        io_i[0] = ~io_i[0];
        repeat (SYNC + 3) @(negedge clk);
        check_val("irq_again", 64'(irq), 64'd1);
        m_stat[0] = 32'h1;
        axi_write(32'hC, 32'h1, 4'hF, 5);
        check_val("irq_cleared2", 64'(irq), 64'd0);
`else
        // Interrupt registers absent: accepted, ignored, read 0.
        axi_write(32'h8, 32'hFFFF_FFFF, 4'hF, 5);
        axi_read(32'h8);
        io_i[0] = ~io_i[0];
        repeat (SYNC + 3) @(negedge clk);
        axi_read(32'hC);
        check_val("irq_off", 64'(irq), 64'd0);
`endif

        // Reset in the middle of a read.
        @(negedge clk);
        req.ar_valid = 1'b1; req.ar.addr = 32'h0;
        @(negedge clk);
        check_val("mid_ar_ready", 64'(resp.ar_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req.ar_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check_val("mid_rst_resp", 64'({resp.ar_ready, resp.r_valid, resp.b_valid}), 64'd0);
        check_val("mid_rst_io_t", io_t, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("mid_rst_io_o", io_o, 64'h0);
        axi_read(32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
